// File: rtl/fir_pkg.sv
// Shared definitions for the symmetric FIR family: accumulator width helper
// and the default 32-tap Q.16 low-pass coefficient half-set.
package fir_pkg;

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + 1 + coef_w + $clog2(taps / 2);
  endfunction

  localparam int DEF_TAPS   = 32;
  localparam int DEF_COEF_W = 20;

  // c[0..15]; the filter mirrors them onto c[31..16].
  localparam logic [DEF_COEF_W-1:0] DEF_COEF [DEF_TAPS/2] = '{
    20'hFFF9E, 20'hFFF86, 20'hFFFA7, 20'h0003B,
    20'h0014B, 20'h0024A, 20'h00222, 20'hFFFE4,
    20'hFFBC5, 20'hFF7CA, 20'hFF74E, 20'hFFD74,
    20'h00B1A, 20'h01DAC, 20'h02F9E, 20'h03AA9
  };

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up of a wide signed accumulator by SHIFT bits,
// followed by saturation to a signed OUT_W result.
module fir_round_sat #(
  parameter int IN_W  = 41,
  parameter int OUT_W = 16,
  parameter int SHIFT = 16
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int R_W = IN_W + 1;
  localparam logic signed [R_W-1:0] RND  = R_W'(1) <<< (SHIFT - 1);
  localparam logic signed [R_W-1:0] MAXV = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [R_W-1:0] MINV = {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [R_W-1:0] biased;
  logic signed [R_W-1:0] r;

  always_comb begin
    biased = R_W'(acc) + RND;
    r      = biased >>> SHIFT;
    sat    = 1'b1;
    if (r > MAXV) begin
      data = MAXV[OUT_W-1:0];
    end else if (r < MINV) begin
      data = MINV[OUT_W-1:0];
    end else begin
      data = r[OUT_W-1:0];
      sat  = 1'b0;
    end
  end

endmodule

// File: rtl/fir_sym_filter.sv
// Fully pipelined symmetric FIR: delay line, pre-add fold, multiply with live
// coefficients, then sum/round/saturate into the output register.
module fir_sym_filter
  import fir_pkg::*;
#(
  parameter int TAPS   = 32,
  parameter int DATA_W = 16,
  parameter int COEF_W = 20,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS/2)-1:0] coef_addr,
  input  logic [COEF_W-1:0]         coef_wdata,
  output logic                      out_valid,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_sat
);

  localparam int HALF  = TAPS / 2;
  localparam int P_W   = DATA_W + 1;
  localparam int M_W   = P_W + COEF_W;
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int CNT_W = $clog2(TAPS + 1);

  // Streaming contract: in_valid has no ready, a sample is taken every cycle it
  // is high. out_valid is a one-cycle pulse; out_data/out_sat hold otherwise.
  logic signed [DATA_W-1:0] tap  [TAPS];
  logic signed [COEF_W-1:0] coef [HALF];
  logic signed [P_W-1:0]    pre  [HALF];
  logic signed [M_W-1:0]    prod [HALF];
  logic [CNT_W-1:0]         cnt;
  logic                     v_tap, v_pre, v_prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  rs_data;
  logic                     rs_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) tap[i] <= '0;
      cnt   <= '0;
      v_tap <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) tap[i] <= '0;
      cnt   <= '0;
      v_tap <= 1'b0;
    end else begin
      // Output only once this sample completes (or follows) a full window.
      v_tap <= in_valid && (cnt >= CNT_W'(TAPS - 1));
      if (in_valid) begin
        tap[0] <= in_data;
        for (int i = 1; i < TAPS; i++) tap[i] <= tap[i-1];
        if (cnt != CNT_W'(TAPS)) cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < HALF; k++) coef[k] <= '0;
    end else if (coef_we) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < HALF; k++) begin
        pre[k]  <= '0;
        prod[k] <= '0;
      end
      v_pre  <= 1'b0;
      v_prod <= 1'b0;
    end else begin
      for (int k = 0; k < HALF; k++) begin
        pre[k]  <= {tap[k][DATA_W-1], tap[k]} + {tap[TAPS-1-k][DATA_W-1], tap[TAPS-1-k]};
        prod[k] <= M_W'(pre[k]) * M_W'(coef[k]);
      end
      v_pre  <= v_tap && !clear;
      v_prod <= v_pre && !clear;
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < HALF; k++) acc = acc + ACC_W'(prod[k]);
  end

  fir_round_sat #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .acc  (acc),
    .data (rs_data),
    .sat  (rs_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= v_prod && !clear;
      if (v_prod && !clear) begin
        out_data <= rs_data;
        out_sat  <= rs_sat;
      end
    end
  end

endmodule
